// File: rtl/line_pkg.sv
// Shared definitions for the line-code sequencer slice.
//   CODE_W                 width of the line code driven to the 7-segment decoder
//   *_DFLT                 default timing/range constants at 50 MHz
//   state_t                sequencer FSM state encoding (2'd3 is illegal)
//   code_up / code_dn      modulo (CODE_MAX+1) step arithmetic
package line_pkg;

  localparam int unsigned CODE_W               = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = 50000;
  localparam int unsigned AUTO_PERIOD_DFLT     = 25000000;
  localparam int unsigned CODE_MAX_DFLT        = 7;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  function automatic logic [CODE_W-1:0] code_up(input logic [CODE_W-1:0] code,
                                                input logic [CODE_W-1:0] max);
    return (code == max) ? '0 : code + 1'b1;
  endfunction

  function automatic logic [CODE_W-1:0] code_dn(input logic [CODE_W-1:0] code,
                                                input logic [CODE_W-1:0] max);
    return (code == '0) ? max : code - 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// registered rising-edge press pulse.
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   RAW    raw, bouncy, asynchronous button level (active-high)
//   LEVEL  accepted (debounced) button level
//   PRESS  one-cycle pulse, the cycle after LEVEL goes 0->1
module btn_debounce
  import line_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int unsigned          CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      LEVEL   <= 1'b0;
      PRESS   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= RAW;
      sync2   <= sync1;
      level_q <= LEVEL;
      // A level is accepted only after DEBOUNCE_CYCLES consecutive
      // differing samples; any agreeing sample restarts the count.
      if (sync2 != LEVEL) begin
        if (cnt == CNT_LAST) begin
          LEVEL <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      PRESS <= LEVEL & ~level_q;
    end
  end

endmodule

// File: rtl/line_code_sequencer.sv
// Generates the 3-bit line code (A/B/C) for the 7-segment line decoder,
// stepped by debounced up/down buttons or by a prescaled auto tick.
//   CLK, RST_N      clock (rising edge) / asynchronous active-low reset
//   BTN_UP, BTN_DN  raw bouncy push-buttons, active-high
//   MODE_AUTO       raw slide switch, 1 = auto stepping
//   A, B, C         registered code, A = MSB
//   STEP            one-cycle pulse in the cycle the code changed
//   WRAP            one-cycle pulse when the code wrapped CODE_MAX<->0
module line_code_sequencer
  import line_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DFLT,
  parameter int unsigned CODE_MAX        = CODE_MAX_DFLT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_UP,
  input  logic BTN_DN,
  input  logic MODE_AUTO,
  output logic A,
  output logic B,
  output logic C,
  output logic STEP,
  output logic WRAP
);

  localparam int unsigned       PW        = $clog2(AUTO_PERIOD);
  localparam logic [PW-1:0]     PRE_LAST  = PW'(AUTO_PERIOD - 1);
  localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(CODE_MAX);

  logic              up_p;
  logic              dn_p;
  logic              unused_up_level;
  logic              unused_dn_level;
  logic              mode_s1;
  logic              auto_req;
  state_t            state;
  state_t            state_next;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              do_up;
  logic              do_dn;
  logic              presc_clr;
  logic              presc_inc;
  logic [CODE_W-1:0] code;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RAW   (BTN_UP),
    .LEVEL (unused_up_level),
    .PRESS (up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .CLK   (CLK),
    .RST_N (RST_N),
    .RAW   (BTN_DN),
    .LEVEL (unused_dn_level),
    .PRESS (dn_p)
  );

  // Mode switch is synchronized only; its bounce just toggles modes briefly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_s1  <= 1'b0;
      auto_req <= 1'b0;
    end else begin
      mode_s1  <= MODE_AUTO;
      auto_req <= mode_s1;
    end
  end

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= MANUAL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MANUAL:  if (auto_req) state_next = AUTO;
      AUTO:    if (!auto_req) state_next = MANUAL;
               else if (dn_p) state_next = PAUSE;
      PAUSE:   if (!auto_req) state_next = MANUAL;
               else if (dn_p) state_next = AUTO;
      default: state_next = MANUAL;
    endcase
  end

  // Dropping auto_req wins over every event in AUTO/PAUSE, so the
  // per-state actions are gated by auto_req there.
  always_comb begin
    do_up     = 1'b0;
    do_dn     = 1'b0;
    presc_clr = 1'b0;
    presc_inc = 1'b0;
    case (state)
      MANUAL: begin
        presc_clr = 1'b1;
        do_up     = up_p & ~dn_p;
        do_dn     = dn_p & ~up_p;
      end
      AUTO: begin
        if (auto_req) begin
          if (tick) begin
            do_up     = 1'b1;
            presc_clr = 1'b1;
          end else if (!dn_p) begin
            presc_inc = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (auto_req) do_up = up_p;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         presc <= '0;
    else if (presc_clr) presc <= '0;
    else if (presc_inc) presc <= presc + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code <= '0;
      STEP <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      STEP <= 1'b0;
      WRAP <= 1'b0;
      if (do_up) begin
        code <= code_up(code, CODE_LAST);
        STEP <= 1'b1;
        WRAP <= (code == CODE_LAST);
      end else if (do_dn) begin
        code <= code_dn(code, CODE_LAST);
        STEP <= 1'b1;
        WRAP <= (code == '0);
      end
    end
  end

  assign {A, B, C} = code;

endmodule
